// File: rtl/gcn_pkg.sv
// Shared GCN datapath geometry, element types and address-width helper.
package gcn_pkg;
   localparam int DEF_FEATURE_ROWS   = 6;
   localparam int DEF_WEIGHT_COLS    = 3;
   localparam int DEF_DOT_PROD_WIDTH = 16;

   typedef logic [DEF_DOT_PROD_WIDTH-1:0] dot_t;
   typedef dot_t [0:DEF_WEIGHT_COLS-1]    row_t;

   // Address width for n entries, never narrower than one bit.
   function automatic int addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/fm_wm_written_tracker.sv
// Per-entry written bits with registered row-ready and all-done status.
module fm_wm_written_tracker
   import gcn_pkg::*;
#(
   parameter int FEATURE_ROWS = DEF_FEATURE_ROWS,
   parameter int WEIGHT_COLS  = DEF_WEIGHT_COLS,
   parameter int ROW_WIDTH    = addr_w(FEATURE_ROWS),
   parameter int COL_WIDTH    = addr_w(WEIGHT_COLS)
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   input  logic                    set,
   input  logic [ROW_WIDTH-1:0]    row,
   input  logic [COL_WIDTH-1:0]    col,
   output logic [FEATURE_ROWS-1:0] row_ready,
   output logic                    all_done
);
   logic [WEIGHT_COLS-1:0]  written     [FEATURE_ROWS];
   logic [WEIGHT_COLS-1:0]  written_nxt [FEATURE_ROWS];
   logic [FEATURE_ROWS-1:0] ready_nxt;

   // Status is derived from the post-edge bits so it rises with the completing write.
   always_comb begin
      for (int r = 0; r < FEATURE_ROWS; r++) begin
         written_nxt[r] = written[r];
         if (set && row == r[ROW_WIDTH-1:0])
            written_nxt[r][col] = 1'b1;
         ready_nxt[r] = &written_nxt[r];
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         for (int r = 0; r < FEATURE_ROWS; r++)
            written[r] <= '0;
         row_ready <= '0;
         all_done  <= 1'b0;
      end else begin
         for (int r = 0; r < FEATURE_ROWS; r++)
            written[r] <= written_nxt[r];
         row_ready <= ready_nxt;
         all_done  <= &ready_nxt;
      end
   end
endmodule

// File: rtl/fm_wm_result_buffer.sv
// FM x WM product store: gated/accumulating writes, registered row reads.
module fm_wm_result_buffer
   import gcn_pkg::*;
#(
   parameter int FEATURE_ROWS   = DEF_FEATURE_ROWS,
   parameter int WEIGHT_COLS    = DEF_WEIGHT_COLS,
   parameter int DOT_PROD_WIDTH = DEF_DOT_PROD_WIDTH,
   parameter int ROW_WIDTH      = addr_w(FEATURE_ROWS),
   parameter int COL_WIDTH      = addr_w(WEIGHT_COLS)
)(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clear,
   input  logic                        wr_en,
   input  logic                        wr_acc,
   input  logic [ROW_WIDTH-1:0]        wr_row,
   input  logic [COL_WIDTH-1:0]        wr_col,
   input  logic [DOT_PROD_WIDTH-1:0]   wr_data,
   input  logic                        rd_en,
   input  logic [ROW_WIDTH-1:0]        rd_row,
   output logic                        rd_valid,
   output logic [0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0] rd_data,
   output logic                        rd_complete,
   output logic [FEATURE_ROWS-1:0]     row_ready,
   output logic                        all_done,
   output logic                        addr_err
);
   localparam logic [ROW_WIDTH:0] NROWS = (ROW_WIDTH+1)'(FEATURE_ROWS);
   localparam logic [COL_WIDTH:0] NCOLS = (COL_WIDTH+1)'(WEIGHT_COLS);

   logic [0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0] mem [FEATURE_ROWS];

   logic                      wr_in;
   logic                      rd_in;
   logic                      wr_ok;
   logic [DOT_PROD_WIDTH-1:0] wr_val;

   assign wr_in  = ({1'b0, wr_row} < NROWS) && ({1'b0, wr_col} < NCOLS);
   assign rd_in  = {1'b0, rd_row} < NROWS;
   assign wr_ok  = wr_en && wr_in && !clear;
   assign wr_val = wr_acc ? mem[wr_row][wr_col] + wr_data : wr_data;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         for (int r = 0; r < FEATURE_ROWS; r++)
            mem[r] <= '0;
      end else if (wr_ok) begin
         mem[wr_row][wr_col] <= wr_val;
      end
   end

   // Reads sample the array before this edge's write lands.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid    <= 1'b0;
         rd_data     <= '0;
         rd_complete <= 1'b0;
      end else if (clear) begin
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            if (rd_in) begin
               rd_data     <= mem[rd_row];
               rd_complete <= row_ready[rd_row];
            end else begin
               rd_data     <= '0;
               rd_complete <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear)
         addr_err <= 1'b0;
      else if ((wr_en && !wr_in) || (rd_en && !rd_in))
         addr_err <= 1'b1;
   end

   fm_wm_written_tracker #(
      .FEATURE_ROWS (FEATURE_ROWS),
      .WEIGHT_COLS  (WEIGHT_COLS),
      .ROW_WIDTH    (ROW_WIDTH),
      .COL_WIDTH    (COL_WIDTH)
   ) u_tracker (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .set       (wr_ok),
      .row       (wr_row),
      .col       (wr_col),
      .row_ready (row_ready),
      .all_done  (all_done)
   );
endmodule

// File: tb/tb_fm_wm_result_buffer.sv
// Directed plus random bench for fm_wm_result_buffer against a matrix model.
module tb_fm_wm_result_buffer;
   import gcn_pkg::*;

   localparam int R = 6;
   localparam int C = 3;
   localparam int W = 16;

   logic           clk = 1'b0;
   logic           rst, clear, wr_en, wr_acc, rd_en;
   logic [2:0]     wr_row, rd_row;
   logic [1:0]     wr_col;
   logic [W-1:0]   wr_data;
   logic           rd_valid, rd_complete, all_done, addr_err;
   logic [0:C-1][W-1:0] rd_data;
   logic [R-1:0]   row_ready;

   int n_chk = 0;
   int n_fail = 0;

   int  m   [R][C];
   bit  wrt [R][C];
   bit  e_err, e_valid, e_cmp;
   logic [0:C-1][W-1:0] e_data = '0;

   always #5 clk = ~clk;

   fm_wm_result_buffer dut (
      .clk         (clk),
      .rst         (rst),
      .clear       (clear),
      .wr_en       (wr_en),
      .wr_acc      (wr_acc),
      .wr_row      (wr_row),
      .wr_col      (wr_col),
      .wr_data     (wr_data),
      .rd_en       (rd_en),
      .rd_row      (rd_row),
      .rd_valid    (rd_valid),
      .rd_data     (rd_data),
      .rd_complete (rd_complete),
      .row_ready   (row_ready),
      .all_done    (all_done),
      .addr_err    (addr_err)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [R-1:0] exp_ready();
      logic [R-1:0] v;
      for (int r = 0; r < R; r++) begin
         v[r] = 1'b1;
         for (int c = 0; c < C; c++)
            if (!wrt[r][c]) v[r] = 1'b0;
      end
      return v;
   endfunction

   // Applies the inputs about to be sampled to the matrix model.
   task automatic model_edge();
      bit rok, wok;
      rok = rd_row < R;
      wok = (wr_row < R) && (wr_col < C);
      if (rst || clear) begin
         for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
               m[r][c] = 0;
               wrt[r][c] = 1'b0;
            end
         e_err = 1'b0;
         e_valid = 1'b0;
         if (rst) begin
            e_data = '0;
            e_cmp = 1'b0;
         end
         return;
      end
      e_valid = rd_en;
      if (rd_en) begin
         if (rok) begin
            for (int c = 0; c < C; c++)
               e_data[c] = W'(m[rd_row][c]);
            e_cmp = exp_ready()[rd_row];
         end else begin
            e_data = '0;
            e_cmp = 1'b0;
            e_err = 1'b1;
         end
      end
      if (wr_en) begin
         if (wok) begin
            if (wr_acc)
               m[wr_row][wr_col] = (m[wr_row][wr_col] + int'(wr_data)) % 65536;
            else
               m[wr_row][wr_col] = int'(wr_data);
            wrt[wr_row][wr_col] = 1'b1;
         end else begin
            e_err = 1'b1;
         end
      end
   endtask

   task automatic cycle();
      model_edge();
      @(posedge clk);
      #1;
      chk("rd_valid", rd_valid, e_valid);
      chk("rd_data", rd_data, e_data);
      chk("rd_complete", rd_complete, e_cmp);
      chk("row_ready", row_ready, exp_ready());
      chk("all_done", all_done, &exp_ready());
      chk("addr_err", addr_err, e_err);
   endtask

   task automatic wr(input int r, input int c, input int d, input bit acc);
      wr_en = 1'b1;
      wr_row = 3'(r);
      wr_col = 2'(c);
      wr_data = W'(d);
      wr_acc = acc;
      cycle();
      wr_en = 1'b0;
   endtask

   task automatic rd(input int r);
      rd_en = 1'b1;
      rd_row = 3'(r);
      cycle();
      rd_en = 1'b0;
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; wr_en = 1'b0; wr_acc = 1'b0; rd_en = 1'b0;
      wr_row = '0; wr_col = '0; wr_data = '0; rd_row = '0;
      cycle();
      rst = 1'b0;

      rd(0);
      chk("rst_rd_valid", rd_valid, 1);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_row_ready", row_ready, 0);

      wr(2, 0, 5, 0);
      wr(2, 1, 6, 0);
      chk("ready2_early", row_ready[2], 0);
      wr(2, 2, 7, 0);
      chk("ready2", row_ready[2], 1);
      rd(2);
      chk("row2", rd_data, {16'd5, 16'd6, 16'd7});
      chk("row2_cmp", rd_complete, 1);

      wr(1, 0, 'hFFFE, 0);
      wr(1, 0, 3, 1);
      rd(1);
      chk("acc1", rd_data[0], 16'h0001);
      wr(1, 0, 4, 1);
      rd(1);
      chk("acc2", rd_data[0], 16'h0005);

      wr_en = 1'b1; wr_row = 3'd3; wr_col = 2'd1; wr_data = 16'd9; wr_acc = 1'b0;
      rd_en = 1'b1; rd_row = 3'd3;
      cycle();
      wr_en = 1'b0;
      chk("same_old", rd_data[1], 0);
      cycle();
      rd_en = 1'b0;
      chk("same_new", rd_data[1], 9);

      wr(6, 0, 77, 0);
      chk("err_set", addr_err, 1);
      cycle();
      chk("err_sticky", addr_err, 1);
      clear = 1'b1;
      cycle();
      clear = 1'b0;
      chk("clr_err", addr_err, 0);
      chk("clr_ready", row_ready, 0);
      rd(2);
      chk("clr_data", rd_data, 0);

      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++) begin
            wr(r, c, r * 16 + c + 1, 0);
            chk("fill_done", all_done, (r == R - 1) && (c == C - 1));
         end

      rd_en = 1'b1;
      for (int i = 0; i < R; i++) begin
         rd_row = 3'(i);
         rst = (i == 3);
         cycle();
         if (i == 3) begin
            chk("rst_valid", rd_valid, 0);
            chk("rst_data", rd_data, 0);
            chk("rst_done", all_done, 0);
         end
      end
      rst = 1'b0;
      rd_en = 1'b0;

      for (int i = 0; i < 600; i++) begin
         rst    = ($urandom_range(0, 79) == 0);
         clear  = ($urandom_range(0, 39) == 0);
         wr_en  = ($urandom_range(0, 3) != 0);
         wr_acc = $urandom_range(0, 1) == 1;
         wr_row = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(6, 7))
                                               : 3'($urandom_range(0, 5));
         wr_col = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         wr_data = W'($urandom);
         rd_en  = ($urandom_range(0, 1) == 1);
         rd_row = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(6, 7))
                                               : 3'($urandom_range(0, 5));
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
